line_ram: RTL and testbench

- Synchronous single-port RAM of 512-bit cache lines, located on the core's external memory bus at byte window 0x8000–0xBFFF.
- The top level decodes chip_select as addr[31:14] == 2 and passes addr[13:0] to this block.
- Shares the read-data return bus with the boot ROM, so its return outputs are tri-stated whenever it is not selected.
- Serves full-line reads and full-line writes, each with one-cycle latency.

---
 rtl/line_ram.sv | 69 ++++++
 tb/tb_line_ram.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/line_ram.sv
// line_ram: single-port 256 x 512-bit line store on the shared external
// memory bus. Full-line reads and writes, one-cycle response, return bus
// tri-stated whenever the block is not selected.
module line_ram #(
   parameter int ADDR_WIDTH = 14,
   parameter int LINE_BITS  = 512
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  chip_select,
   input  logic                  write_enable,
   input  logic                  addr_valid,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic                  data_valid,
   input  logic [LINE_BITS-1:0]  data_i,
   output logic                  data_ready,
   output logic [LINE_BITS-1:0]  data_o
);

   localparam int OFF_BITS   = 6;
   localparam int IDX_BITS   = ADDR_WIDTH - OFF_BITS;
   localparam int LINE_COUNT = 2 ** IDX_BITS;

   logic [LINE_BITS-1:0] r_mem [LINE_COUNT];
   logic [IDX_BITS-1:0]  r_idx;
   logic                 r_pend;

   logic [IDX_BITS-1:0]  w_idx;
   logic                 w_accept;
   logic                 w_wr;
   logic                 w_rd;
   logic                 w_unused_off;

   // Byte offset within the line is ignored: addresses align down to the line.
   assign w_idx        = addr[ADDR_WIDTH-1:OFF_BITS];
   assign w_unused_off = ^addr[OFF_BITS-1:0];

   // Reset beats a simultaneous request; a write without data is dropped.
   assign w_accept = chip_select & addr_valid & ~rst;
   assign w_wr     = w_accept & write_enable & data_valid;
   assign w_rd     = w_accept & ~write_enable;

   // Array write port; contents survive reset so this can map onto block RAM.
   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[w_idx] <= data_i;
      end
   end

   // Response control: latch the line index and flag a response for next cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pend <= 1'b0;
         r_idx  <= '0;
      end else if (w_wr || w_rd) begin
         r_pend <= 1'b1;
         r_idx  <= w_idx;
      end else begin
         r_pend <= 1'b0;
      end
   end

   // Return bus is shared with the boot ROM: drive only while selected.
   // data_o reads the array at the registered index, so a write shows the
   // new line on the following cycle and idle cycles hold the last line.
   assign data_ready = chip_select ? r_pend        : 1'bz;
   assign data_o     = chip_select ? r_mem[r_idx]  : {LINE_BITS{1'bz}};

endmodule

// File: tb/tb_line_ram.sv
// tb_line_ram: directed test sequence for line_ram with immediate assertions.
module tb_line_ram;

   localparam int AW = 14;
   localparam int LB = 512;

   logic          clk = 1'b0;
   logic          rst;
   logic          chip_select;
   logic          write_enable;
   logic          addr_valid;
   logic [AW-1:0] addr;
   logic          data_valid;
   logic [LB-1:0] data_i;
   wire           data_ready;
   wire  [LB-1:0] data_o;

   int errors = 0;
   int checks = 0;

   logic [LB-1:0] LA, LB_, LC, L0, L6, LJ, LONE, LF;

   line_ram #(.ADDR_WIDTH(AW), .LINE_BITS(LB)) dut (
      .clk          (clk),
      .rst          (rst),
      .chip_select  (chip_select),
      .write_enable (write_enable),
      .addr_valid   (addr_valid),
      .addr         (addr),
      .data_valid   (data_valid),
      .data_i       (data_i),
      .data_ready   (data_ready),
      .data_o       (data_o)
   );

   always #5 clk = ~clk;

   // One active edge, then settle to the falling edge for sampling.
   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_bit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_line(input string tag, input logic [LB-1:0] obs, input logic [LB-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Bus released: the strobe must not be driven high.
   task automatic chk_not_high(input string tag, input logic obs);
      checks++;
      assert (obs !== 1'b1) else begin
         errors++;
         $error("FAIL %s observed=%b expected=not 1", tag, obs);
      end
   endtask

   task automatic chk_line_not(input string tag, input logic [LB-1:0] obs, input logic [LB-1:0] bad);
      checks++;
      assert (obs !== bad) else begin
         errors++;
         $error("FAIL %s observed=%h expected=anything but that", tag, obs);
      end
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [LB-1:0] d);
      chip_select = 1'b1; addr_valid = 1'b1; write_enable = 1'b1; data_valid = 1'b1;
      addr = a; data_i = d;
      cycle();
      addr_valid = 1'b0; write_enable = 1'b0; data_valid = 1'b0;
   endtask

   task automatic do_read(input logic [AW-1:0] a);
      chip_select = 1'b1; addr_valid = 1'b1; write_enable = 1'b0; data_valid = 1'b0;
      addr = a;
      cycle();
      addr_valid = 1'b0;
   endtask

   initial begin
      LA   = {16{32'hAAAA5555}};
      LB_  = {16{32'hBBBB0001}};
      LC   = {16{32'hCCCC0002}};
      L0   = {16{32'h01234567}};
      L6   = {16{32'h0F0F1234}};
      LJ   = {16{32'h5A5A5A5A}};
      LONE = 512'h1;
      LF   = 512'hF;

      rst = 1'b1; chip_select = 1'b1; addr_valid = 1'b1; write_enable = 1'b0;
      data_valid = 1'b0; addr = '0; data_i = '0;
      @(negedge clk);

      // 1: reset with a request asserted
      cycle();
      chk_bit("rst_cycle1", data_ready, 1'b0);
      cycle();
      chk_bit("rst_cycle2", data_ready, 1'b0);
      rst = 1'b0; addr_valid = 1'b0;
      cycle();
      chk_bit("rst_release", data_ready, 1'b0);
      chip_select = 1'b0;
      #1;
      chk_not_high("desel_ready", data_ready);
      chip_select = 1'b1;
      @(negedge clk);

      // 2: write then read of line 1
      do_write(14'h0040, {16{32'hDEADBEEF}});
      chk_bit("wr_ready", data_ready, 1'b1);
      chk_line("wr_through", data_o, {16{32'hDEADBEEF}});
      do_read(14'h0040);
      chk_bit("rd_ready", data_ready, 1'b1);
      chk_line("rd_data", data_o, {16{32'hDEADBEEF}});
      cycle();
      chk_bit("idle_ready", data_ready, 1'b0);
      chk_line("idle_hold", data_o, {16{32'hDEADBEEF}});
      chip_select = 1'b0;
      #1;
      chk_line_not("desel_data", data_o, {16{32'hDEADBEEF}});
      chip_select = 1'b1;
      @(negedge clk);

      // 3: last line, misaligned read, line 0 untouched
      do_write(14'h0000, L0);
      do_write(14'h3FC0, LONE);
      do_read(14'h3FFF);
      chk_bit("wrap_ready", data_ready, 1'b1);
      chk_line("wrap_data", data_o, LONE);
      do_read(14'h0000);
      chk_line("line0_data", data_o, L0);

      // 4: back-to-back writes, then back-to-back reads with addr_valid held
      chip_select = 1'b1; addr_valid = 1'b1; write_enable = 1'b1; data_valid = 1'b1;
      addr = 14'h0040; data_i = LA;
      cycle();
      chk_line("b2b_wr_a", data_o, LA);
      addr = 14'h0080; data_i = LB_;
      cycle();
      chk_bit("b2b_wr_ready", data_ready, 1'b1);
      chk_line("b2b_wr_b", data_o, LB_);
      addr = 14'h00C0; data_i = LC;
      cycle();
      chk_line("b2b_wr_c", data_o, LC);
      write_enable = 1'b0; data_valid = 1'b0;
      addr = 14'h0040;
      cycle();
      chk_bit("b2b_rd_ready_a", data_ready, 1'b1);
      chk_line("b2b_rd_a", data_o, LA);
      addr = 14'h0080;
      cycle();
      chk_bit("b2b_rd_ready_b", data_ready, 1'b1);
      chk_line("b2b_rd_b", data_o, LB_);
      addr = 14'h00C0;
      cycle();
      chk_bit("b2b_rd_ready_c", data_ready, 1'b1);
      chk_line("b2b_rd_c", data_o, LC);
      addr_valid = 1'b0;
      cycle();
      chk_bit("b2b_end_ready", data_ready, 1'b0);

      // 5: deselected write and write without data are both ignored
      chip_select = 1'b0; addr_valid = 1'b1; write_enable = 1'b1; data_valid = 1'b1;
      addr = 14'h0040; data_i = LJ;
      cycle();
      chk_not_high("desel_wr_ready", data_ready);
      chk_line_not("desel_wr_data", data_o, LC);
      chip_select = 1'b1; addr_valid = 1'b0; write_enable = 1'b0; data_valid = 1'b0;
      cycle();
      chk_bit("desel_after_ready", data_ready, 1'b0);
      do_read(14'h0040);
      chk_line("desel_mem_kept", data_o, LA);
      chip_select = 1'b1; addr_valid = 1'b1; write_enable = 1'b1; data_valid = 1'b0;
      addr = 14'h0080; data_i = LJ;
      cycle();
      chk_bit("nodata_ready", data_ready, 1'b0);
      addr_valid = 1'b0; write_enable = 1'b0;
      do_read(14'h0080);
      chk_line("nodata_mem_kept", data_o, LB_);

      // 6: reset collides with a write
      do_write(14'h0100, L6);
      rst = 1'b1; chip_select = 1'b1; addr_valid = 1'b1; write_enable = 1'b1; data_valid = 1'b1;
      addr = 14'h0100; data_i = LF;
      cycle();
      chk_bit("rstcol_ready", data_ready, 1'b0);
      chk_line("rst_idx_zero", data_o, L0);
      rst = 1'b0; addr_valid = 1'b0; write_enable = 1'b0; data_valid = 1'b0;
      cycle();
      do_read(14'h0100);
      chk_bit("rstcol_rd_ready", data_ready, 1'b1);
      chk_line("rstcol_old_data", data_o, L6);
      do_read(14'h0040);
      chk_line("rst_mem_intact", data_o, LA);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Hard stop in case the sequence ever stalls.
   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
